rv32imf_apu_arbiter: RTL

Shares one FP APU port (the FPU wrapper's master interface) between NREQ requester ports, e.g. core plus accelerator or two harts.
- Round-robin arbitration on the request channel.
- Issue order is recorded in an ID FIFO.
- Each response is routed back to the requester that issued it.
- Sits between the requesters' APU master ports and the single FP wrapper instance.

---
 rtl/rv32imf_apu_core_pkg.sv | 24 ++
 rtl/rv32imf_apu_id_fifo.sv | 62 ++++++
 rtl/rv32imf_apu_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/rv32imf_apu_core_pkg.sv
// Shared APU interface constants for the rv32imf core, plus the arbiter's
// request payload type.
//   APU_NARGS_CPU     number of 32-bit operands per APU request
//   APU_WOP_CPU       width of the {vec, mod, op} field
//   APU_NDSFLAGS_CPU  width of the {int_fmt, src_fmt, dst_fmt, rm} field
//   APU_NUSFLAGS_CPU  width of the response status flags
//   APU_ARB_MAX_NREQ  largest requester count the APU arbiter supports
package rv32imf_apu_core_pkg;

    localparam int unsigned APU_NARGS_CPU    = 3;
    localparam int unsigned APU_WOP_CPU      = 6;
    localparam int unsigned APU_NDSFLAGS_CPU = 15;
    localparam int unsigned APU_NUSFLAGS_CPU = 5;

    localparam int unsigned APU_ARB_MAX_NREQ = 8;

    // Everything a requester hands to the FP wrapper in one request.
    typedef struct packed {
        logic [APU_NARGS_CPU-1:0][31:0] operands;
        logic [APU_WOP_CPU-1:0]         op;
        logic [APU_NDSFLAGS_CPU-1:0]    flags;
    } apu_payload_t;

endpackage

// File: rtl/rv32imf_apu_id_fifo.sv
// Issue-order FIFO holding the requester ID of every APU op in flight.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push, wdata    enqueue wdata (ignored while full)
//   pop            dequeue the head (ignored while empty)
//   full, empty    occupancy status from the registered count
//   head           ID at the front of the queue (valid when !empty)
//   count          number of IDs stored
module rv32imf_apu_id_fifo #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CNTW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A pop in the same cycle does not free a slot for a push when full.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= (wr_ptr == PTRW'(DEPTH - 1)) ? '0 : wr_ptr + PTRW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTRW'(DEPTH - 1)) ? '0 : rd_ptr + PTRW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rv32imf_apu_arbiter.sv
// Shares one FP APU master port between NREQ requesters. Requests are
// arbitrated round-robin with no added latency; the winner's ID is queued
// on each handshake and used to steer the in-order response back.
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   req_i/gnt_o                       per-requester request / grant
//   operands_i, op_i, flags_i         per-requester payload
//   rvalid_o, rdata_o, rflags_o       response (valid one-hot, data shared)
//   apu_req_o/apu_gnt_i               downstream request handshake
//   apu_operands_o/op_o/flags_o       downstream payload (winner's)
//   apu_rvalid_i/rdata_i/rflags_i     downstream response
//   busy_o                            at least one op in flight
//   err_o                             sticky: response arrived with none in flight
module rv32imf_apu_arbiter
    import rv32imf_apu_core_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned MAX_OUTST = 1
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic [NREQ-1:0]                             req_i,
    output logic [NREQ-1:0]                             gnt_o,
    input  logic [NREQ-1:0][APU_NARGS_CPU-1:0][31:0]    operands_i,
    input  logic [NREQ-1:0][APU_WOP_CPU-1:0]            op_i,
    input  logic [NREQ-1:0][APU_NDSFLAGS_CPU-1:0]       flags_i,
    output logic [NREQ-1:0]                             rvalid_o,
    output logic [31:0]                                 rdata_o,
    output logic [APU_NUSFLAGS_CPU-1:0]                 rflags_o,
    output logic                                        apu_req_o,
    input  logic                                        apu_gnt_i,
    output logic [APU_NARGS_CPU-1:0][31:0]              apu_operands_o,
    output logic [APU_WOP_CPU-1:0]                      apu_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]                 apu_flags_o,
    input  logic                                        apu_rvalid_i,
    input  logic [31:0]                                 apu_rdata_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]                 apu_rflags_i,
    output logic                                        busy_o,
    output logic                                        err_o
);

    localparam int unsigned IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNTW   = $clog2(MAX_OUTST + 1);
    localparam int          NREQ_I = int'(NREQ);

    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  winner;
    logic            any_req;
    int              cand;
    logic            handshake;
    apu_payload_t    win_payload;

    logic            fifo_full;
    logic            fifo_empty;
    logic [IDW-1:0]  fifo_head;
    logic [CNTW-1:0] fifo_count;

    // First asserted request at or after rr_ptr, searching upward with wrap.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        cand    = 0;
        for (int i = 0; i < NREQ_I; i++) begin
            cand = (int'(rr_ptr) + i) % NREQ_I;
            if (!any_req && req_i[IDW'(cand)]) begin
                any_req = 1'b1;
                winner  = IDW'(cand);
            end
        end
    end

    always_comb begin
        win_payload = '0;
        if (any_req) begin
            win_payload.operands = operands_i[winner];
            win_payload.op       = op_i[winner];
            win_payload.flags    = flags_i[winner];
        end
    end

    assign apu_operands_o = win_payload.operands;
    assign apu_op_o       = win_payload.op;
    assign apu_flags_o    = win_payload.flags;

    assign apu_req_o = any_req && !fifo_full;
    assign handshake = apu_req_o && apu_gnt_i;

    always_comb begin
        gnt_o = '0;
        if (handshake) begin
            gnt_o[winner] = 1'b1;
        end
    end

    // Pointer moves past the winner only when an op actually issues.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
        end else if (handshake) begin
            rr_ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
        end
    end

    rv32imf_apu_id_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (IDW)
    ) u_id_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (handshake),
        .wdata  (winner),
        .pop    (apu_rvalid_i),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (fifo_head),
        .count  (fifo_count)
    );

    // Responses with nothing in flight are dropped and flagged.
    always_comb begin
        rvalid_o = '0;
        if (apu_rvalid_i && !fifo_empty) begin
            rvalid_o[fifo_head] = 1'b1;
        end
    end

    assign rdata_o  = apu_rdata_i;
    assign rflags_o = apu_rflags_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (apu_rvalid_i && fifo_empty) begin
            err_o <= 1'b1;
        end
    end

    assign busy_o = (fifo_count != '0);

endmodule
